// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, multi-bit shift/rotate ops, MSB-first serialiser.
// Latency: load/op results are registered (1 cycle); serialiser moves one bit per accepted transfer.
// Backpressure: sout_valid holds with sout stable until sout_ready; a load or reset aborts a transfer in progress.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   load, din             parallel load (highest priority after reset, aborts serialisation)
//   op_en, op, shift_amt  shift/rotate op, executed only when idle
//   shift_in              fill bit for SLL/SRL and for serialiser shifts
//   start, count          begin serialising count bits (clamped to N), only when idle
//   sout, sout_valid,
//   sout_ready            serial output handshake; sout is always dout[N-1]
//   busy, done            busy in SEND/DONE; done pulses for one cycle at completion
//   dout                  register contents
module univ_shift_reg #(
  parameter int N  = 16,
  parameter int AW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [N-1:0]  din,
  input  logic          op_en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] shift_amt,
  input  logic          shift_in,
  input  logic          start,
  input  logic [AW-1:0] count,
  output logic          sout,
  output logic          sout_valid,
  input  logic          sout_ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  dout
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [AW-1:0] N_AW = AW'(N);

  state_t        state, state_nxt;
  logic [N-1:0]  dout_nxt;
  logic [AW-1:0] rem, rem_nxt;

  // Shift/rotate datapath
  logic [N-1:0]   op_res;
  logic [AW-1:0]  k_sat;
  logic [AW-1:0]  k_rot;
  logic           fill_r;
  logic [2*N-1:0] wide_l, wide_r, rot_l, rot_r;

  always_comb begin
    // Logical/arithmetic shifts saturate at N so the result becomes all fill bits.
    k_sat  = (shift_amt > N_AW) ? N_AW : shift_amt;
    k_rot  = shift_amt % N_AW;
    fill_r = (op == 3'b011) ? dout[N-1] : shift_in;
    // Shifting a double-width word pulls fill bits (or the rotated copy) in from the side.
    wide_l = {dout, {N{shift_in}}} << k_sat;
    wide_r = {{N{fill_r}}, dout} >> k_sat;
    rot_l  = {dout, dout} << k_rot;
    rot_r  = {dout, dout} >> k_rot;
    op_res = dout;
    case (op)
      3'b001:         op_res = wide_l[2*N-1:N];
      3'b010, 3'b011: op_res = wide_r[N-1:0];
      3'b100:         op_res = rot_l[2*N-1:N];
      3'b101:         op_res = rot_r[N-1:0];
      default:        op_res = dout;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_nxt  = state;
    dout_nxt   = dout;
    rem_nxt    = rem;
    sout       = dout[N-1];
    sout_valid = (state == SEND);
    busy       = (state != IDLE);
    done       = (state == DONE);

    if (load) begin
      // Load wins over everything but reset and abandons any serialisation silently.
      dout_nxt  = din;
      state_nxt = IDLE;
    end else begin
      case (state)
        SEND: begin
          if (sout_ready) begin
            dout_nxt = {dout[N-2:0], shift_in};
            rem_nxt  = rem - AW'(1);
            if (rem == AW'(1)) state_nxt = DONE;
          end
        end
        DONE: state_nxt = IDLE;
        default: begin
          if (start) begin
            // start takes precedence over op_en; a zero count completes immediately.
            if (count == '0) begin
              state_nxt = DONE;
            end else begin
              rem_nxt   = (count > N_AW) ? N_AW : count;
              state_nxt = SEND;
            end
          end else if (op_en) begin
            dout_nxt = op_res;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dout  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      dout  <= dout_nxt;
      rem   <= rem_nxt;
    end
  end

endmodule
